bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq.sv | 176 +++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (double-dabble), one input bit per clock.
// Feeds the 4-digit display nibble selector with packed BCD digits.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   conversion request, sampled only in IDLE
//   bin_in   in   [BIN_W-1:0] binary value, captured on the accepting edge
//   busy     out  high during SHIFT and DONE
//   done     out  one-cycle pulse, bcd_out/overflow valid from this cycle
//   bcd_out  out  [4*DIGITS-1:0] packed BCD, digit0 in [3:0]; held between conversions
//   overflow out  last captured bin_in exceeded MAX_VAL; updated with bcd_out
//
// Optional build macro: BIN_TO_BCD_AUTO_CONVERT_EN
//   When defined, IDLE also launches a conversion whenever bin_in differs from
//   the value captured by the most recent conversion (last_bin).
//
// state | meaning
// IDLE  | waiting for start (or a changed bin_in with auto-convert)
// SHIFT | one shift-add-3 iteration per cycle, BIN_W iterations
// DONE  | result published, done pulse high, returns to IDLE

module bin_to_bcd_seq #(
    parameter int BIN_W   = 14,
    parameter int DIGITS  = 4,
    parameter int MAX_VAL = 9999
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [BCD_W-1:0] SAT_BCD = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [BCD_W-1:0]         acc_q, acc_d;
    logic [BIN_W-1:0]         sr_q, sr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic                     ovf_q, ovf_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [BCD_W-1:0]         adj;
    logic [BCD_W+BIN_W-1:0]   shift_word;
    logic [BCD_W-1:0]         acc_step;
    logic [BIN_W-1:0]         sr_step;
    logic                     go;

`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
    logic [BIN_W-1:0]         last_bin_q, last_bin_d;
`endif

    // One double-dabble iteration: per-nibble +3 (truncated, so no carry can
    // cross a nibble boundary), then shift the combined word left by one.
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        shift_word = {adj, sr_q} << 1;
        acc_step   = shift_word[BCD_W+BIN_W-1:BIN_W];
        sr_step    = shift_word[BIN_W-1:0];
    end

`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
    assign go = start || (bin_in != last_bin_q);
`else
    assign go = start;
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
        last_bin_d = last_bin_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (go) begin
                    sr_d       = bin_in;
                    acc_d      = '0;
                    cnt_d      = CNT_W'(BIN_W - 1);
                    ovf_pend_d = (bin_in > BIN_W'(MAX_VAL));
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
                    last_bin_d = bin_in;
`endif
                end
            end
            SHIFT: begin
                acc_d = acc_step;
                sr_d  = sr_step;
                if (cnt_q == '0) begin
                    // Final iteration: publish its result on the same edge.
                    bcd_d   = ovf_pend_q ? SAT_BCD : acc_step;
                    ovf_d   = ovf_pend_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            sr_q       <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
            last_bin_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
            last_bin_q <= last_bin_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq
// Directed and randomized bench for bin_to_bcd_seq. Expected BCD values come
// from decimal arithmetic on the input value (saturating above 9999).

module tb_bin_to_bcd_seq;

    localparam int BIN_W = 14;
    localparam int LAT   = 14;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [BIN_W-1:0]  bin_in;
    logic              busy;
    logic              done;
    logic [15:0]       bcd_out;
    logic              overflow;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int e0       = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(4), .MAX_VAL(9999)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_conv(input int v);
        @(negedge clk);
        bin_in = BIN_W'(v);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int exp_lat, input int v, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(cyc - e0), 32'(exp_lat));
        chk({tag, "_bcd"}, 32'(bcd_out), 32'(ref_bcd(v)));
        chk({tag, "_ovf"}, 32'(overflow), 32'(v > 9999));
    endtask

    task automatic post_done(input string tag);
        @(negedge clk);
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int v, v2, dc;
        reset_n = 1'b0;
        start   = 1'b0;
        bin_in  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            repeat (6) @(negedge clk);
            chk("rst_bcd", 32'(bcd_out), 32'h0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_ovf", 32'(overflow), 32'd0);
        end

`ifdef BIN_TO_BCD_AUTO_CONVERT_EN
        chk("auto_idle_cnt", 32'(done_cnt), 32'd0);
        @(negedge clk);
        bin_in = 14'd15;
        e0 = cyc + 1;
        wait_done(LAT, 15, "auto15");
        repeat (20) @(negedge clk);
        bin_in = 14'd15;
        chk("auto_after15_cnt", 32'(done_cnt), 32'd1);
        repeat (20) @(negedge clk);
        chk("auto_hold15_cnt", 32'(done_cnt), 32'd1);
        bin_in = 14'd16;
        e0 = cyc + 1;
        wait_done(LAT, 16, "auto16");
        repeat (20) @(negedge clk);
        chk("auto_total_cnt", 32'(done_cnt), 32'd2);
        start_conv(16);
        wait_done(LAT, 16, "auto_explicit");
        post_done("auto_explicit");
`else
        start_conv(1234);
        wait_done(LAT, 1234, "c1234");
        post_done("c1234");

        start_conv(0);
        wait_done(LAT, 0, "c0");
        post_done("c0");
        start_conv(9999);
        wait_done(LAT, 9999, "c9999");
        post_done("c9999");
        start_conv(10000);
        wait_done(LAT, 10000, "c10000");
        post_done("c10000");
        start_conv(16383);
        wait_done(LAT, 16383, "cmax");
        post_done("cmax");

        // Second start during SHIFT must be ignored and not queued.
        dc = done_cnt;
        start_conv(509);
        repeat (4) @(negedge clk);
        bin_in = 14'd42;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(LAT, 509, "ign");
        repeat (20) @(negedge clk);
        chk("ign_one_done", 32'(done_cnt - dc), 32'd1);
        chk("ign_idle", 32'(busy), 32'd0);
        chk("ign_held", 32'(bcd_out), 32'h0509);

        // Reset mid-conversion clears outputs immediately.
        start_conv(4321);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_bcd", 32'(bcd_out), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        start_conv(77);
        wait_done(LAT, 77, "c77");
        post_done("c77");

        // start held high: back-to-back, one IDLE cycle between done and capture.
        v  = 8765;
        v2 = 10321;
        @(negedge clk);
        bin_in = BIN_W'(v);
        start  = 1'b1;
        @(negedge clk);
        e0 = cyc;
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(LAT, v, "b2b_first");
        bin_in = BIN_W'(v2);
        e0 = cyc;
        @(negedge clk);
        chk("b2b_gap_done", 32'(done), 32'd0);
        chk("b2b_gap_busy", 32'(busy), 32'd0);
        wait_done(LAT + 2, v2, "b2b_second");
        start = 1'b0;
        post_done("b2b");

        // Randomized conversions with input disturbance during SHIFT.
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) v = 9990 + int'($urandom_range(0, 20));
            else            v = int'($urandom_range(0, 16383));
            start_conv(v);
            @(negedge clk);
            bin_in = BIN_W'($urandom_range(0, 16383));
            wait_done(LAT, v, "rand");
            post_done("rand");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
